npu_host_responder: RTL

NPU_HOST_RESPONDER -- requirements
Module: npu_host_responder

---
 rtl/npu_pkg.sv | 22 ++
 rtl/npu_host_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/npu_pkg.sv
// Shared definitions for the NPU host responder: FSM states, header/response
// magic values, header field offsets and response status bit positions.
package npu_pkg;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PAY  = 2'd1,
        S_CSUM = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [7:0] HDR_MAGIC  = 8'hA5;
    localparam logic [7:0] RESP_MAGIC = 8'h5A;

    localparam int unsigned HDR_MAGIC_LSB = 24;
    localparam int unsigned HDR_TAG_LSB   = 16;
    localparam int unsigned HDR_LEN_LSB   = 0;

    localparam int unsigned STAT_CSUM_BIT = 0;
    localparam int unsigned STAT_OVF_BIT  = 1;

endpackage

// File: rtl/npu_host_responder.sv
// Parses header/payload packets from the PCIe controller, forwards payload to the NPU core
// and returns a one-word status response. Define NPU_RESP_CSUM_EN to check a trailer word.
module npu_host_responder
    import npu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_LEN    = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic                  busy,
    output logic [15:0]           pkt_cnt,
    output logic [7:0]            err_cnt
);

`ifdef NPU_RESP_CSUM_EN
    localparam state_t PAY_DONE = S_CSUM;
`else
    localparam state_t PAY_DONE = S_RESP;
`endif

    state_t                state_q, state_d;
    logic [7:0]            tag_q, tag_d;
    logic [15:0]           rem_q, rem_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  ovf_q, ovf_d;
    logic                  cerr_q, cerr_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic [15:0]           pkt_q, pkt_d;
    logic [7:0]            err_q, err_d;
    logic                  err_inc;

    logic [7:0]  hdr_magic;
    logic [7:0]  hdr_tag;
    logic [15:0] hdr_len;
    logic [7:0]  status;

    assign hdr_magic = s_data[HDR_MAGIC_LSB +: 8];
    assign hdr_tag   = s_data[HDR_TAG_LSB +: 8];
    assign hdr_len   = s_data[HDR_LEN_LSB +: 16];

    always_comb begin
        status                = 8'h00;
        status[STAT_CSUM_BIT] = cerr_q;
        status[STAT_OVF_BIT]  = ovf_q;
    end

    always_comb begin
        state_d   = state_q;
        tag_d     = tag_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        cerr_d    = cerr_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        pkt_d     = pkt_q;
        err_inc   = 1'b0;
        s_ready   = 1'b0;

        // Output register drains in any state; a new load below overrides it.
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        case (state_q)
            S_HDR: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (hdr_magic != HDR_MAGIC) begin
                        err_inc = 1'b1;
                    end else begin
                        tag_d   = hdr_tag;
                        rem_d   = hdr_len;
                        acc_d   = '0;
                        cerr_d  = 1'b0;
                        ovf_d   = 32'(hdr_len) > MAX_LEN;
                        err_inc = 32'(hdr_len) > MAX_LEN;
                        state_d = (hdr_len == 16'd0) ? PAY_DONE : S_PAY;
                    end
                end
            end
            S_PAY: begin
                // Oversized packets are drained without touching the output register.
                s_ready = ovf_q || !m_valid_q || m_ready;
                if (s_valid && s_ready) begin
                    acc_d = acc_q ^ s_data;
                    if (!ovf_q) begin
                        m_data_d  = s_data;
                        m_valid_d = 1'b1;
                        m_last_d  = (rem_q == 16'd1);
                    end
                    if (rem_q != 16'd0) begin
                        rem_d = rem_q - 16'd1;
                    end
                    if (rem_q <= 16'd1) begin
                        state_d = PAY_DONE;
                    end
                end
            end
            S_CSUM: begin
`ifdef NPU_RESP_CSUM_EN
                s_ready = 1'b1;
                if (s_valid) begin
                    cerr_d  = (s_data != acc_q);
                    err_inc = (s_data != acc_q);
                    state_d = S_RESP;
                end
`else
                state_d = S_RESP;
`endif
            end
            S_RESP: begin
                if (r_ready) begin
                    pkt_d   = pkt_q + 16'd1;
                    state_d = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase

        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q     <= '0;
            rem_q     <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            cerr_q    <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            pkt_q     <= '0;
            err_q     <= '0;
        end else begin
            tag_q     <= tag_d;
            rem_q     <= rem_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            cerr_q    <= cerr_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            pkt_q     <= pkt_d;
            err_q     <= err_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign r_valid = (state_q == S_RESP);
    assign r_data  = (state_q == S_RESP) ? {RESP_MAGIC, tag_q, status, 8'h00} : '0;
    assign busy    = (state_q != S_HDR);
    assign pkt_cnt = pkt_q;
    assign err_cnt = err_q;

endmodule
